// File: rtl/mlu_nibble_seq.sv
// mlu_nibble_seq
//   Multi-cycle MLU sequencer. It walks the latched A/B operands one nibble
//   per clock through an external combinational mlu_slice. It chains the
//   slice prop/gen outputs into a ripple carry and assembles the result and
//   the flags.
//
// Parameters
//   NIBBLES        operand width in nibbles (2..16); word width is 4*NIBBLES
//
// Ports
//   i_clk          clock, rising edge
//   i_n_rst        asynchronous active-low reset
//   i_start        request pulse, accepted only while o_busy is low
//   i_op           MLU opcode, latched when a request is accepted
//   i_a, i_b       operands, latched when a request is accepted
//   o_busy         high while nibbles are in flight (state RUN)
//   o_done         one-cycle pulse; o_result and the flags are valid
//   o_result       assembled result, held until the next accepted start
//   o_c_out        carry out of the top nibble
//   o_zero         high when the whole result is zero
//   o_v            signed overflow (present only with MLU_SEQ_OVERFLOW_EN)
//   o_slice_addr   {cin, op, B nibble, A nibble} driven to the slice
//   i_slice_out    slice response: [3:0] result, [4] prop, [5] gen, [6] zero
//
// Build option
//   MLU_SEQ_OVERFLOW_EN  adds the o_v output and its overflow logic.
//
// Opcode encoding (local copy of the common MLU set)
//   0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 NOP.
//   Only ADD and SUB need special handling here.

module mlu_nibble_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_n_rst,
    input  logic                   i_start,
    input  logic [2:0]             i_op,
    input  logic [4*NIBBLES-1:0]   i_a,
    input  logic [4*NIBBLES-1:0]   i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*NIBBLES-1:0]   o_result,
    output logic                   o_c_out,
    output logic                   o_zero,
`ifdef MLU_SEQ_OVERFLOW_EN
    output logic                   o_v,
`endif
    output logic [11:0]            o_slice_addr,
    input  logic [7:0]             i_slice_out
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    localparam logic [2:0] MLU_SUB = 3'd2;
`ifdef MLU_SEQ_OVERFLOW_EN
    localparam logic [2:0] MLU_ADD = 3'd1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a, r_b, r_result;
    logic [2:0]      r_op;
    logic            r_cin, r_c_out, r_zero;
    logic            w_accept, w_last, w_cout;
    logic [3:0]      w_a_nib, w_b_nib;
    logic            w_unused;

    assign w_last   = (r_cnt == CW'(NIBBLES - 1));
    assign w_a_nib  = r_a[4*r_cnt +: 4];
    assign w_b_nib  = r_b[4*r_cnt +: 4];
    // Ripple carry through the slice: generate, or propagate the incoming carry.
    assign w_cout   = i_slice_out[5] | (i_slice_out[4] & r_cin);
    // Bit 7 of the slice response carries nothing for this block.
    assign w_unused = i_slice_out[7];

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_slice_addr = 12'h000;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy       = 1'b1;
                o_slice_addr = {r_cin, r_op, w_b_nib, w_a_nib};
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                // A start seen during the DONE cycle chains straight into RUN.
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 3'd0;
            r_cnt    <= '0;
            r_cin    <= 1'b0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_op     <= i_op;
            r_cnt    <= '0;
            // Subtract runs as A + ~B + 1, so its first carry-in is 1.
            r_cin    <= (i_op == MLU_SUB);
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_zero   <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_result[4*r_cnt +: 4] <= i_slice_out[3:0];
            r_cin    <= w_cout;
            r_zero   <= r_zero & i_slice_out[6];
            r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) r_c_out <= w_cout;
        end
    end

    assign o_result = r_result;
    assign o_c_out  = r_c_out;
    assign o_zero   = r_zero;

`ifdef MLU_SEQ_OVERFLOW_EN
    logic r_v;
    logic w_a_msb, w_b_msb, w_r_msb;

    assign w_a_msb = r_a[W-1];
    assign w_b_msb = r_b[W-1];
    // The MSB of the result arrives from the slice on the final RUN edge.
    assign w_r_msb = i_slice_out[3];

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_v <= 1'b0;
        end else if (w_accept) begin
            r_v <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            if (r_op == MLU_ADD)
                r_v <= (w_a_msb == w_b_msb) & (w_r_msb != w_a_msb);
            else if (r_op == MLU_SUB)
                r_v <= (w_a_msb != w_b_msb) & (w_r_msb != w_a_msb);
            else
                r_v <= 1'b0;
        end
    end

    assign o_v = r_v;
`endif

endmodule

// File: tb/tb_mlu_nibble_seq.sv
// Bench for mlu_nibble_seq. It provides a behavioural mlu_slice that answers
// combinationally from o_slice_addr. Each accepted request pushes a
// word-level expected result into a queue, and a monitor pops and compares
// that entry on every o_done.
module tb_mlu_nibble_seq;
    localparam int N = 8;
    localparam int W = 4 * N;

    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR  = 3'd4, OP_XOR = 3'd5, OP_NOT = 3'd6;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, c_out, zero;
    logic [W-1:0]  result;
    logic [11:0]   slice_addr;
    logic [7:0]    slice_out;
`ifdef MLU_SEQ_OVERFLOW_EN
    logic          v;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    mlu_nibble_seq #(.NIBBLES(N)) dut (
        .i_clk        (clk),
        .i_n_rst      (rst_n),
        .i_start      (start),
        .i_op         (op),
        .i_a          (a),
        .i_b          (b),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_c_out      (c_out),
        .o_zero       (zero),
`ifdef MLU_SEQ_OVERFLOW_EN
        .o_v          (v),
`endif
        .o_slice_addr (slice_addr),
        .i_slice_out  (slice_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream slice: one nibble of the MLU with carry-lookahead prop/gen.
    logic       s_cin, s_p, s_g;
    logic [2:0] s_op;
    logic [3:0] s_a, s_b, s_r;
    logic [4:0] s_t;
    always_comb begin
        {s_cin, s_op, s_b, s_a} = slice_addr;
        s_t = 5'd0;
        s_r = s_a;
        s_p = 1'b0;
        s_g = 1'b0;
        case (s_op)
            OP_ADD: begin s_t = {1'b0, s_a} + {1'b0, s_b};  s_r = s_t[3:0] + {3'b0, s_cin};
                          s_g = s_t[4]; s_p = (s_t[3:0] == 4'hF); end
            OP_SUB: begin s_t = {1'b0, s_a} + {1'b0, ~s_b}; s_r = s_t[3:0] + {3'b0, s_cin};
                          s_g = s_t[4]; s_p = (s_t[3:0] == 4'hF); end
            OP_AND: s_r = s_a & s_b;
            OP_OR:  s_r = s_a | s_b;
            OP_XOR: s_r = s_a ^ s_b;
            OP_NOT: s_r = ~s_a;
            default: s_r = s_a;
        endcase
        // Bit 7 is driven high so a design that leaks it is noticed.
        slice_out = {1'b1, (s_r == 4'h0), s_g, s_p, s_r};
    end

    // Word-level reference: what the whole operation means arithmetically.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] s;
        s = '0;
        e.r = x; e.c = 1'b0; e.v = 1'b0; e.cyc = 0;
        case (o)
            OP_ADD: begin s = {1'b0, x} + {1'b0, y}; e.r = s[W-1:0]; e.c = s[W];
                          e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]); end
            OP_SUB: begin s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1); e.r = s[W-1:0]; e.c = s[W];
                          e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]); end
            OP_AND: e.r = x & y;
            OP_OR:  e.r = x | y;
            OP_XOR: e.r = x ^ y;
            OP_NOT: e.r = ~x;
            default: e.r = x;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", 64'(result), 64'(e.r));
                chk("c_out", 64'(c_out), 64'(e.c));
                chk("zero", 64'(zero), 64'(e.z));
                chk("busy_in_done", 64'(busy), 64'(0));
                chk("addr_in_done", 64'(slice_addr), 64'(0));
`ifdef MLU_SEQ_OVERFLOW_EN
                chk("v", 64'(v), 64'(e.v));
`endif
            end
        end
    end

    task automatic push(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int dcyc);
        exp_t e;
        e = model(o, x, y);
        e.cyc = dcyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Issue one request from idle; DONE is due N cycles after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        push(o, x, y, cyc + N);
        chk("busy_after_accept", 64'(busy), 64'(1));
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_busy"},   64'(busy),       64'(0));
        chk({tag, "_done"},   64'(done),       64'(0));
        chk({tag, "_result"}, 64'(result),     64'(0));
        chk({tag, "_c_out"},  64'(c_out),      64'(0));
        chk({tag, "_zero"},   64'(zero),       64'(0));
        chk({tag, "_addr"},   64'(slice_addr), 64'(0));
`ifdef MLU_SEQ_OVERFLOW_EN
        chk({tag, "_v"},      64'(v),          64'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        logic [2:0]   o2;
        logic [W-1:0] a2, b2;
        rst_n = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        #3 rst_n = 1'b0;
        #1 reset_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Carry through every nibble.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);  wait_idle();
        chk("add_wrap_result", 64'(result), 64'(0));
        chk("add_wrap_cout", 64'(c_out), 64'(1));
        issue(OP_SUB, 32'h5, 32'h7);          wait_idle();
        chk("sub_neg_result", 64'(result), 64'(32'hFFFF_FFFE));
        issue(OP_SUB, 32'h1234_5678, 32'h1234_5678); wait_idle();
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);  wait_idle();
        chk("add_ovf_result", 64'(result), 64'(32'h8000_0000));

        // A second request during RUN is ignored.
        issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'h1111_1111; b = 32'h2222_2222;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("xor_hold_result", 64'(result), 64'(32'h0FF0_0FF0));
        chk("xor_hold_cout", 64'(c_out), 64'(0));

        // Reset mid-RUN at CNT=3 drops the operation.
        issue(OP_ADD, 32'hDEAD_BEEF, 32'h0123_4567);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 reset_outputs_zero("midrun_reset");
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_resume_busy", 64'(busy), 64'(0));
        issue(OP_ADD, 32'h1, 32'h2); wait_idle();
        chk("after_reset_result", 64'(result), 64'(3));

        // START held across DONE: back-to-back operations, DONE N+1 apart.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            @(negedge clk);
            acc = cyc;
            push(op, a, b, acc + N);
            o2 = 3'($urandom_range(0, 7)); a2 = $urandom; b2 = $urandom;
            op = o2; a = a2; b = b2;
            push(o2, a2, b2, acc + 2 * N + 1);
            while (cyc < acc + N + 1) @(negedge clk);
            start = 1'b0;
            wait_idle();
        end

        // Randomized traffic with occasional gaps.
        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
